// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer: drives one PE datapath controller's instruction port over
// a batch of tiles. Accepts a tile command on Cmd_rdy/Cmd_ack and latches the PE
// loop sizes. Per tile it issues a start pulse, then counts psum handshakes while
// relaying stall/resume, and ends each tile with a reset pulse. Done_rdy/Done_ack
// reports batch completion upstream.
//
// Optional feature: define PESEQ_TIMEOUT_EN to add a RUN-state watchdog that
// sets the sticky o_error and abandons the batch when no psum handshake arrives
// for 2^TOWD-1 RUN cycles. Without it, o_error is tied 0.
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   Cmd_rdy / Cmd_ack              command handshake (ntile + loop sizes)
//   i_ntile, i_pch, i_r, i_pm, i_tw command payload
//   o_pch, o_r, o_pm, o_tw         latched PE configuration
//   o_inst_dval/start/reset/stall  instruction port to the PE
//   i_psum_rdy, i_psum_ack         monitored PE psum handshake
//   i_stall_req                    downstream backpressure
//   i_abort                        abandon the current batch
//   Done_rdy / Done_ack            batch completion handshake
//   o_tile_idx, o_busy, o_error    status
module pe_tile_sequencer #(
  parameter int unsigned NTILEW = 16,
  parameter int unsigned TOWD   = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              Cmd_rdy,
  output logic              Cmd_ack,
  input  logic [NTILEW-1:0] i_ntile,
  input  logic [3:0]        i_pch,
  input  logic [3:0]        i_r,
  input  logic [3:0]        i_pm,
  input  logic [5:0]        i_tw,
  output logic [3:0]        o_pch,
  output logic [3:0]        o_r,
  output logic [3:0]        o_pm,
  output logic [5:0]        o_tw,
  output logic              o_inst_dval,
  output logic              o_inst_start,
  output logic              o_inst_reset,
  output logic              o_inst_stall,
  input  logic              i_psum_rdy,
  input  logic              i_psum_ack,
  input  logic              i_stall_req,
  input  logic              i_abort,
  output logic              Done_rdy,
  input  logic              Done_ack,
  output logic [NTILEW-1:0] o_tile_idx,
  output logic              o_busy,
  output logic              o_error
);

  localparam int unsigned CNTW = 18;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_HOLD, S_FLUSH, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NTILEW-1:0] ntile_q, ntile_d;
  logic [NTILEW-1:0] tile_idx_q, tile_idx_d;
  logic [3:0]        pch_q, pch_d, r_q, r_d, pm_q, pm_d;
  logic [5:0]        tw_q, tw_d;
  logic [CNTW-1:0]   total_q, total_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic dval_q, dval_d, start_q, start_d, rst_q, rst_d, stall_q, stall_d;

  logic              hs_c;
  logic              last_hs_c;
  logic              timeout_c;
  logic [CNTW-1:0]   prod_c;

  assign hs_c      = i_psum_rdy && i_psum_ack;
  assign last_hs_c = hs_c && (cnt_q == (total_q - CNTW'(1)));
  assign prod_c    = CNTW'(pch_q) * CNTW'(r_q) * CNTW'(pm_q) * CNTW'(tw_q);

`ifdef PESEQ_TIMEOUT_EN
  // Watchdog: fires in the RUN cycle in which the counter would reach all ones.
  localparam logic [TOWD-1:0] WD_LAST = {{(TOWD-1){1'b1}}, 1'b0};
  logic [TOWD-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  assign timeout_c = (state_q == S_RUN) && (wd_q == WD_LAST);

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (state_q == S_RUN && !i_abort && !hs_c) begin
      if (timeout_c) err_d = 1'b1;
      else           wd_d  = wd_q + TOWD'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q;
`else
  logic [TOWD-1:0] wd_unused;
  assign wd_unused = '0;
  assign timeout_c = 1'b0;
  assign o_error   = 1'b0;
`endif

  // Next-state, datapath updates and registered instruction decode.
  always_comb begin
    state_d    = state_q;
    ntile_d    = ntile_q;
    tile_idx_d = tile_idx_q;
    pch_d      = pch_q;
    r_d        = r_q;
    pm_d       = pm_q;
    tw_d       = tw_q;
    total_d    = total_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;

    unique case (state_q)
      S_IDLE: begin
        if (Cmd_rdy && ack_q) begin
          ntile_d    = i_ntile;
          pch_d      = i_pch;
          r_d        = i_r;
          pm_d       = i_pm;
          tw_d       = i_tw;
          tile_idx_d = '0;
          cnt_d      = '0;
          abort_d    = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        total_d = prod_c;
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (prod_c == '0 || ntile_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Priority: abort, final handshake, watchdog, stall.
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (last_hs_c) begin
          state_d = S_FLUSH;
        end else if (hs_c) begin
          cnt_d = cnt_q + CNTW'(1);
          if (i_stall_req) state_d = S_HOLD;
        end else if (timeout_c) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (i_stall_req) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (last_hs_c) begin
          state_d = S_FLUSH;
        end else begin
          if (hs_c) cnt_d = cnt_q + CNTW'(1);
          if (!i_stall_req) state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        cnt_d = '0;
        if (abort_q) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
        end else if (tile_idx_q == (ntile_q - NTILEW'(1))) begin
          state_d = S_DONE;
        end else begin
          tile_idx_d = tile_idx_q + NTILEW'(1);
          state_d    = S_START;
        end
      end
      S_DONE: begin
        if (Done_ack && done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs register the decode of the upcoming state; HOLD is only occupied
    // while backpressure is asserted, and HOLD->RUN carries the resume word.
    ack_d   = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    start_d = (state_d == S_START);
    rst_d   = (state_d == S_FLUSH);
    stall_d = (state_d == S_HOLD);
    dval_d  = start_d || rst_d || stall_d ||
              (state_q == S_HOLD && state_d == S_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ntile_q    <= '0;
      tile_idx_q <= '0;
      pch_q      <= '0;
      r_q        <= '0;
      pm_q       <= '0;
      tw_q       <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dval_q     <= 1'b0;
      start_q    <= 1'b0;
      rst_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ntile_q    <= ntile_d;
      tile_idx_q <= tile_idx_d;
      pch_q      <= pch_d;
      r_q        <= r_d;
      pm_q       <= pm_d;
      tw_q       <= tw_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dval_q     <= dval_d;
      start_q    <= start_d;
      rst_q      <= rst_d;
      stall_q    <= stall_d;
    end
  end

  assign Cmd_ack      = ack_q;
  assign o_busy       = busy_q;
  assign Done_rdy     = done_q;
  assign o_inst_dval  = dval_q;
  assign o_inst_start = start_q;
  assign o_inst_reset = rst_q;
  assign o_inst_stall = stall_q;
  assign o_tile_idx   = tile_idx_q;
  assign o_pch        = pch_q;
  assign o_r          = r_q;
  assign o_pm         = pm_q;
  assign o_tw         = tw_q;

endmodule
